// File: rtl/pwl_table_loader.sv
// rtl/pwl_table_loader.sv - shadow/active breakpoint table loader for the PWL selector; optional order check under PWL_ORDER_CHECK_EN
module pwl_table_loader #(
  parameter int NX = 16,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [1:0]           wr_sel,
  input  logic [4:0]           wr_idx,
  input  logic [DW-1:0]        wr_data,
  output logic [NX*DW-1:0]     x_flat,
  output logic [(NX+1)*DW-1:0] m_flat,
  output logic [(NX+1)*DW-1:0] c_flat,
  output logic                 tbl_valid,
  output logic                 tbl_update,
  output logic                 err_addr,
  output logic                 err_order
);

  localparam logic [4:0] X_LAST  = 5'(NX - 1);
  localparam logic [4:0] MC_LAST = 5'(NX);

  typedef enum logic [1:0] {IDLE, CHECK, COPY} state_t;

  state_t        state;
  logic [DW-1:0] x_sh [NX];
  logic [DW-1:0] m_sh [NX+1];
  logic [DW-1:0] c_sh [NX+1];

`ifdef PWL_ORDER_CHECK_EN
  localparam logic [3:0] K_LAST = 4'(NX - 2);
  logic [3:0] k;

  // Strict sign-magnitude less-than; -0 and +0 map to the same value so they never pass.
  function automatic logic sm_lt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0] va;
    logic signed [DW:0] vb;
    va = $signed({2'b00, a[DW-2:0]});
    vb = $signed({2'b00, b[DW-2:0]});
    if (a[DW-1]) va = -va;
    if (b[DW-1]) vb = -vb;
    return va < vb;
  endfunction
`else
  assign err_order = 1'b0;
`endif

  // Requests are only taken in IDLE, so the shadow can never change under the check or copy.
  assign wr_ready = (state == IDLE) && !reset;

  // Loader state machine: shadow writes, optional order check, single-edge shadow->active copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tbl_valid  <= 1'b0;
      tbl_update <= 1'b0;
      err_addr   <= 1'b0;
      x_flat     <= '0;
      m_flat     <= '0;
      c_flat     <= '0;
      for (int i = 0; i < NX; i++) x_sh[i] <= '0;
      for (int i = 0; i < NX + 1; i++) begin
        m_sh[i] <= '0;
        c_sh[i] <= '0;
      end
`ifdef PWL_ORDER_CHECK_EN
      err_order <= 1'b0;
      k         <= '0;
`endif
    end else begin
      tbl_update <= 1'b0;
      err_addr   <= 1'b0;
`ifdef PWL_ORDER_CHECK_EN
      err_order  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (wr_valid) begin
            case (wr_sel)
              2'd0: begin
                if (wr_idx <= X_LAST) x_sh[wr_idx[3:0]] <= wr_data;
                else                  err_addr <= 1'b1;
              end
              2'd1, 2'd2: begin
                if (wr_idx <= MC_LAST) begin
                  if (wr_sel == 2'd1) m_sh[wr_idx] <= wr_data;
                  else                c_sh[wr_idx] <= wr_data;
                end else begin
                  err_addr <= 1'b1;
                end
              end
              default: begin
`ifdef PWL_ORDER_CHECK_EN
                state <= CHECK;
                k     <= '0;
`else
                state <= COPY;
`endif
              end
            endcase
          end
        end
`ifdef PWL_ORDER_CHECK_EN
        CHECK: begin
          if (!sm_lt(x_sh[k], x_sh[k + 4'd1])) begin
            err_order <= 1'b1;
            state     <= IDLE;
          end else if (k == K_LAST) begin
            state <= COPY;
          end else begin
            k <= k + 4'd1;
          end
        end
`endif
        COPY: begin
          for (int i = 0; i < NX; i++) x_flat[DW*i +: DW] <= x_sh[i];
          for (int i = 0; i < NX + 1; i++) begin
            m_flat[DW*i +: DW] <= m_sh[i];
            c_flat[DW*i +: DW] <= c_sh[i];
          end
          tbl_valid  <= 1'b1;
          tbl_update <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwl_table_loader.sv
// tb/tb_pwl_table_loader.sv - scoreboard bench for pwl_table_loader against a queue/array reference model
module tb_pwl_table_loader;

`ifdef PWL_ORDER_CHECK_EN
  localparam int LAT      = 16;
  localparam bit ORDER_ON = 1'b1;
`else
  localparam int LAT      = 1;
  localparam bit ORDER_ON = 1'b0;
`endif
  localparam int K_UPD  = 0;
  localparam int K_ADDR = 1;
  localparam int K_ORD  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [1:0]   wr_sel = 2'd0;
  logic [4:0]   wr_idx = 5'd0;
  logic [15:0]  wr_data = 16'd0;
  logic [255:0] x_flat;
  logic [271:0] m_flat;
  logic [271:0] c_flat;
  logic         tbl_valid, tbl_update, err_addr, err_order;

  pwl_table_loader dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
    .x_flat(x_flat), .m_flat(m_flat), .c_flat(c_flat),
    .tbl_valid(tbl_valid), .tbl_update(tbl_update),
    .err_addr(err_addr), .err_order(err_order)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int hs = 0;
  always @(posedge clk) if (wr_valid && wr_ready) hs <= hs + 1;

  typedef struct {
    int           kind;
    int           cyc;
    logic [271:0] x;
    logic [271:0] m;
    logic [271:0] c;
  } ev_t;

  ev_t          q[$];
  logic [15:0]  sx [16];
  logic [15:0]  smm [17];
  logic [15:0]  scc [17];
  logic [271:0] ax_f, am_f, ac_f;
  bit           committed;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int sm_val(input logic [15:0] v);
    int mag;
    mag = int'(v[14:0]);
    return v[15] ? -mag : mag;
  endfunction

  function automatic logic [271:0] shadow_flat(input int sel);
    logic [271:0] r;
    r = '0;
    for (int i = 0; i < 17; i++) begin
      if (sel == 0 && i < 16) r[16*i +: 16] = sx[i];
      else if (sel == 1)      r[16*i +: 16] = smm[i];
      else if (sel == 2)      r[16*i +: 16] = scc[i];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sx[i] = '0;
      smm[i] = '0;
      scc[i] = '0;
    end
    ax_f = '0; am_f = '0; ac_f = '0;
    committed = 1'b0;
    q.delete();
  endtask

  task automatic model_commit(input int t);
    ev_t e;
    e.x = '0; e.m = '0; e.c = '0;
    if (ORDER_ON) begin
      for (int k = 0; k < 15; k++) begin
        if (!(sm_val(sx[k]) < sm_val(sx[k+1]))) begin
          e.kind = K_ORD;
          e.cyc  = t + 1 + k;
          q.push_back(e);
          return;
        end
      end
    end
    ax_f = shadow_flat(0);
    am_f = shadow_flat(1);
    ac_f = shadow_flat(2);
    committed = 1'b1;
    e.kind = K_UPD; e.cyc = t + LAT;
    e.x = ax_f; e.m = am_f; e.c = ac_f;
    q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request, hold it until accepted, then fold it into the model.
  task automatic wr(input int sel, input int idx, input logic [15:0] data, input bit track, output int t);
    int budget;
    ev_t e;
    budget = 0;
    wr_valid = 1'b1; wr_sel = 2'(sel); wr_idx = 5'(idx); wr_data = data;
    while (!wr_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!wr_ready) begin
      chk("ready_timeout", 272'(wr_ready), 272'(1));
      wr_valid = 1'b0;
      t = 0;
      return;
    end
    @(posedge clk); #1;
    t = cyc;
    wr_valid = 1'b0;
    e.x = '0; e.m = '0; e.c = '0; e.kind = K_ADDR; e.cyc = t;
    if (sel == 0) begin
      if (idx < 16) sx[idx] = data; else q.push_back(e);
    end else if (sel == 1 || sel == 2) begin
      if (idx < 17) begin
        if (sel == 1) smm[idx] = data; else scc[idx] = data;
      end else q.push_back(e);
    end else if (track) begin
      model_commit(t);
    end
  endtask

  task automatic expect_ev(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", 272'(kind), 272'(e.kind));
      chk("event_cycle", 272'(cyc), 272'(e.cyc));
      if (kind == K_UPD) begin
        chk("upd_x_flat", 272'(x_flat), e.x);
        chk("upd_m_flat", m_flat, e.m);
        chk("upd_c_flat", c_flat, e.c);
        chk("upd_tbl_valid", 272'(tbl_valid), 272'(1));
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tbl_update) expect_ev(K_UPD);
        if (err_addr)   expect_ev(K_ADDR);
        if (err_order)  expect_ev(K_ORD);
        if (q.size() > 0 && q[0].cyc < cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL missing_event: kind %0d due cycle %0d, none by cycle %0d", q[0].kind, q[0].cyc, cyc);
          void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic load_ordered_x();
    int v, t;
    v = -int'($urandom_range(0, 2000));
    for (int i = 0; i < 16; i++) begin
      wr(0, i, (v < 0) ? {1'b1, 15'(-v)} : {1'b0, 15'(v)}, 1'b1, t);
      v += 1 + int'($urandom_range(0, 500));
    end
  endtask

  task automatic drive_main();
    int t, tc, h0, rel, r;
    model_clear();
    wait_cycles(3);
    chk("rst_wr_ready", 272'(wr_ready), 272'(0));
    chk("rst_x_flat", 272'(x_flat), 272'(0));
    chk("rst_m_flat", m_flat, 272'(0));
    chk("rst_flags", 272'({tbl_valid, tbl_update, err_addr, err_order}), 272'(0));
    reset = 1'b0;
    #1;
    chk("release_wr_ready", 272'(wr_ready), 272'(1));

    // Ordered reference table.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) wr(0, i, 16'(16'h0100 * (i + 1)), 1'b1, t);
      wr(1, i, 16'(i), 1'b1, t);
      wr(2, i, 16'h8000 | 16'(i), 1'b1, t);
    end
    wr(3, 0, 16'h0, 1'b1, tc);
    wait_cycles(LAT + 1);
    chk("tp_x1", 272'(x_flat[31:16]), 272'(16'h0200));
    chk("tp_c16", 272'(c_flat[271:256]), 272'(16'h8010));
    chk("tp_tbl_valid", 272'(tbl_valid), 272'(1));

    // Out-of-range indices.
    wr(0, 16, 16'hdead, 1'b1, t);
    chk("addr_ready_x", 272'(wr_ready), 272'(1));
    wr(1, 17, 16'hbeef, 1'b1, t);
    chk("addr_ready_m", 272'(wr_ready), 272'(1));

    // Unordered x[5].
    wr(0, 5, 16'h0100, 1'b1, t);
    wr(3, 0, 16'h0, 1'b1, tc);
    wait_cycles(LAT + 1);
    chk("ord_x5_active", 272'(x_flat[95:80]), ORDER_ON ? 272'(16'h0600) : 272'(16'h0100));

    // Negative breakpoints with -0 against +0.
    wr(0, 5, 16'h0600, 1'b1, t);
    wr(0, 0, 16'h8005, 1'b1, t);
    wr(0, 1, 16'h8003, 1'b1, t);
    wr(0, 2, 16'h8000, 1'b1, t);
    wr(0, 3, 16'h0000, 1'b1, t);
    wr(3, 0, 16'h0, 1'b1, tc);
    wait_cycles(LAT + 1);
    wr(0, 3, 16'h0001, 1'b1, t);
    wr(3, 0, 16'h0, 1'b1, tc);
    wait_cycles(LAT + 1);
    chk("neg_x3_active", 272'(x_flat[63:48]), 272'(16'h0001));

    // Request held across the commit window.
    h0 = hs;
    wr(3, 0, 16'h0, 1'b1, tc);
    wr(0, 0, 16'h8006, 1'b1, t);
    chk("hold_accept_cycle", 272'(t), 272'(tc + LAT + 1));
    chk("hold_handshakes", 272'(hs - h0), 272'(2));

    // Reset in the middle of a commit.
    wr(3, 0, 16'h0, !ORDER_ON, tc);
    wait_cycles(6);
    reset = 1'b1;
    #1;
    model_clear();
    chk("abort_x_flat", 272'(x_flat), 272'(0));
    chk("abort_m_flat", m_flat, 272'(0));
    chk("abort_c_flat", c_flat, 272'(0));
    chk("abort_flags", 272'({tbl_valid, tbl_update, err_addr, err_order, wr_ready}), 272'(0));
    wait_cycles(2);
    reset = 1'b0;
    rel = cyc;
    #1;
    chk("abort_release_ready", 272'(wr_ready), 272'(1));
    wr(0, 3, 16'h1234, 1'b1, t);
    chk("abort_first_accept", 272'(t), 272'(rel + 1));

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       wr(3, 0, 16'h0, 1'b1, t);
      else if (r < 13) load_ordered_x();
      else             wr(int'($urandom_range(0, 2)), int'($urandom_range(0, 17)), 16'($urandom), 1'b1, t);
    end

    wait_cycles(LAT + 3);
    chk("final_x_flat", 272'(x_flat), ax_f);
    chk("final_m_flat", m_flat, am_f);
    chk("final_c_flat", c_flat, ac_f);
    chk("final_tbl_valid", 272'(tbl_valid), 272'(committed));
    chk("final_queue_empty", 272'(q.size()), 272'(0));
  endtask

  initial begin
    fork
      monitor();
      drive_main();
      begin
        #1000000;
        n_cmp++; n_bad++;
        $display("FAIL global_timeout: got cycle %0d want completion", cyc);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
